// File: rtl/player_hit_edge_detect.sv
`default_nettype none
// player_hit_edge_detect: classifies player/wall overlaps by sprite edge band,
// pulses per hit one clock later, and publishes per-frame hit summaries.
module player_hit_edge_detect #(
    parameter int OBJECT_WIDTH_X = 32,
    parameter int OBJECT_HIGHT_Y = 32,
    parameter int EDGE_W         = 4
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               game_on,
    input  logic [10:0]        pixelX,
    input  logic [10:0]        pixelY,
    input  logic signed [10:0] topLeftX,
    input  logic signed [10:0] topLeftY,
    input  logic               playerDR,
    input  logic               wallDR,
    output logic               column_collision,
    output logic [3:0]         HitEdgeCode,
    output logic [3:0]         first_hit_code,
    output logic [3:0]         frame_hit_code,
    output logic [7:0]         hit_count
);

    typedef enum logic [1:0] {
        IDLE_ST  = 2'd0,
        SCAN_ST  = 2'd1,
        LATCH_ST = 2'd2
    } state_t;

    localparam logic signed [11:0] WIDTH_S  = 12'(OBJECT_WIDTH_X);
    localparam logic signed [11:0] HEIGHT_S = 12'(OBJECT_HIGHT_Y);
    localparam logic signed [11:0] EDGE_S   = 12'(EDGE_W);
    localparam logic signed [11:0] RIGHT_S  = 12'(OBJECT_WIDTH_X - EDGE_W);
    localparam logic signed [11:0] BOTTOM_S = 12'(OBJECT_HIGHT_Y - EDGE_W);

    state_t             state;
    state_t             next_state;
    logic signed [11:0] ox;
    logic signed [11:0] oy;
    logic               overlap;
    logic [3:0]         code;
    logic [3:0]         pipe_code;
    logic               hit;
    logic [3:0]         acc_code;
    logic [7:0]         acc_count;

    // 12-bit signed offsets: off-screen sprite origins still give true offsets
    assign ox = $signed({1'b0, pixelX}) - $signed({topLeftX[10], topLeftX});
    assign oy = $signed({1'b0, pixelY}) - $signed({topLeftY[10], topLeftY});

    assign overlap = playerDR && wallDR && game_on
                     && !ox[11] && (ox < WIDTH_S)
                     && !oy[11] && (oy < HEIGHT_S);

    always_comb begin
        code = 4'b0000;
        if (overlap) begin
            code[3] = (ox < EDGE_S);
            code[2] = (oy < EDGE_S);
            code[1] = (ox >= RIGHT_S);
            code[0] = (oy >= BOTTOM_S);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pipe_code <= 4'b0000;
        end else begin
            pipe_code <= code;
        end
    end

    assign hit              = (state != IDLE_ST) && (pipe_code != 4'b0000);
    assign column_collision = hit;
    assign HitEdgeCode      = hit ? pipe_code : 4'b0000;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE_ST;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE_ST:  if (startOfFrame && game_on) next_state = SCAN_ST;
            SCAN_ST: begin
                if (!game_on)          next_state = IDLE_ST;
                else if (startOfFrame) next_state = LATCH_ST;
            end
            LATCH_ST: next_state = game_on ? SCAN_ST : IDLE_ST;
            default:  next_state = IDLE_ST;
        endcase
    end

    // A hit visible on the boundary cycle opens the new frame's accumulation
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            acc_code       <= 4'b0000;
            acc_count      <= 8'd0;
            first_hit_code <= 4'b0000;
            frame_hit_code <= 4'b0000;
            hit_count      <= 8'd0;
        end else begin
            if (state == SCAN_ST && startOfFrame) begin
                frame_hit_code <= acc_code;
                hit_count      <= acc_count;
            end
            if (next_state == IDLE_ST) begin
                acc_code       <= 4'b0000;
                acc_count      <= 8'd0;
                first_hit_code <= 4'b0000;
            end else if (state == SCAN_ST && startOfFrame) begin
                acc_code       <= HitEdgeCode;
                acc_count      <= {7'd0, hit};
                first_hit_code <= HitEdgeCode;
            end else if (hit) begin
                acc_code <= acc_code | pipe_code;
                if (acc_count != 8'hFF) begin
                    acc_count <= acc_count + 8'd1;
                end
                if (first_hit_code == 4'b0000) begin
                    first_hit_code <= pipe_code;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/player_hit_edge_detect.md
PLAYER_HIT_EDGE_DETECT -- requirements
Module: player_hit_edge_detect

Interface
REQ-001 Parameters SHALL be: OBJECT_WIDTH_X, default 32, player sprite width in pixels; OBJECT_HIGHT_Y, default 32, sprite height in pixels; EDGE_W, default 4, edge-band thickness in pixels.
REQ-002 The module SHALL have the following ports, one per line (name, direction, width, meaning):
- clk  in  1  system clock.
- resetN  in  1  reset, asynchronous, active-low.
- startOfFrame  in  1  single-cycle pulse at each frame start.
- game_on  in  1  detection enable.
- pixelX  in  11  current scan X.
- pixelY  in  11  current scan Y.
- topLeftX  in  11 signed  player top-left X.
- topLeftY  in  11 signed  player top-left Y.
- playerDR  in  1  player pixel drawing request.
- wallDR  in  1  column or wall drawing request.
- column_collision  out  1  single-cycle hit pulse.
- HitEdgeCode  out  4  edge code of the current hit.
- first_hit_code  out  4  code of the first hit in the current frame.
- frame_hit_code  out  4  OR of all codes from the previous frame.
- hit_count  out  8  saturating count of hits in the previous frame.

Function
REQ-003 Edge-code bits SHALL be LEFT=4'b1000, TOP=4'b0100, RIGHT=4'b0010, BOTTOM=4'b0001; a corner hit SHALL be the OR of its two bits.
REQ-004 The block SHALL compute ox=pixelX-topLeftX and oy=pixelY-topLeftY in 12-bit signed arithmetic with no truncation before the range check.
REQ-005 A pixel SHALL be an overlap when playerDR, wallDR and game_on are all 1, and 0<=ox<OBJECT_WIDTH_X, and 0<=oy<OBJECT_HIGHT_Y.
REQ-006 Bit classification for an overlap: LEFT if ox<EDGE_W; RIGHT if ox>=OBJECT_WIDTH_X-EDGE_W; TOP if oy<EDGE_W; BOTTOM if oy>=OBJECT_HIGHT_Y-EDGE_W.
REQ-007 An overlap whose code is 4'b0000 (interior) SHALL NOT produce a collision.
REQ-008 Latency SHALL be exactly one clock: an overlap with a nonzero code at cycle N drives column_collision=1 and HitEdgeCode=code in cycle N+1.
REQ-009 HitEdgeCode SHALL be 0 in every cycle where column_collision=0.
REQ-010 The state machine SHALL have three states: IDLE_ST, SCAN_ST and LATCH_ST.
REQ-011 IDLE_ST -> SCAN_ST SHALL occur on the first startOfFrame with game_on=1.
REQ-012 SCAN_ST -> LATCH_ST SHALL occur on startOfFrame.
REQ-013 LATCH_ST SHALL last one cycle, then go to SCAN_ST, or to IDLE_ST if game_on=0.
REQ-014 While in SCAN_ST, if game_on falls the block SHALL go to IDLE_ST on the next cycle.
REQ-015 In SCAN_ST the block SHALL accumulate: acc_code |= code, and acc_count increments by 1 per registered collision, saturating at 255.
REQ-016 In SCAN_ST, the first nonzero code after the last frame boundary SHALL load first_hit_code; it SHALL hold for the rest of the frame.
REQ-017 On the startOfFrame cycle, frame_hit_code<=acc_code and hit_count<=acc_count; acc_code, acc_count and first_hit_code SHALL clear.
REQ-018 Published values SHALL be stable from the cycle after startOfFrame until the next startOfFrame.
REQ-019 A collision registered in the same cycle as startOfFrame SHALL belong to the new frame: it is included in the new acc and new first_hit_code, and excluded from the published values.
REQ-020 In LATCH_ST the collision pipeline SHALL keep running; no pixel SHALL be dropped.
REQ-021 In IDLE_ST all accumulators SHALL be held at 0, and column_collision and HitEdgeCode SHALL be 0.
REQ-022 frame_hit_code and hit_count SHALL retain their last published values in IDLE_ST.
REQ-023 A pixel overlap with sprite coordinates partly off-screen (negative topLeftX or topLeftY) SHALL still be classified per REQ-004 to REQ-006.

Reset
REQ-024 When resetN=0, asynchronously: state=IDLE_ST; all outputs and accumulators 0; the pipeline register cleared.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame; after release, no outputs are published until two startOfFrame pulses with game_on=1.

Verification
REQ-026 The bench SHALL cover the following scenarios:
- V1: topLeft=(100,100); wall overlap at pixel (101,115) -> next cycle column_collision=1, HitEdgeCode=4'b1000; following cycle both 0.
- V2: overlap at pixel (131,131) -> HitEdgeCode=4'b0011. Overlap at (115,115) -> no pulse, acc unchanged.
- V3: hits LEFT, then TOP, then LEFT in one frame, then startOfFrame -> frame_hit_code=4'b1100, hit_count=3; first_hit_code during the frame=4'b1000, cleared to 0 after startOfFrame.
- V4: 300 hits in one frame -> hit_count=255. Hit on the startOfFrame cycle -> not counted in the published value; counted as 1 in the next frame.
- V5: topLeftX=-5, pixelX=0, wall present -> ox=5, code excludes LEFT. pixelX=1000 with topLeftX=-5 -> no overlap.
- V6: resetN pulsed low mid-frame after 2 hits -> all outputs 0 immediately. game_on=0 -> no pulses, state IDLE_ST, published values retained.
